// File: rtl/text_mem_ctrl.sv
// Write-side controller for the 256x8 VGA text RAM: cursor, control codes, blank-fill clear.
// Optional TEXT_WRAP_CLEAR_EN: wrapping off the last symbol/row clears the screen instead.
//   state  | meaning
//   IDLE   | waiting for a byte from the character source
//   WRITE  | one pending RAM write (printable byte or backspace blank)
//   CLEAR  | blank-filling addresses 0..COLS*ROWS-1
module text_mem_ctrl #(
   parameter int         COLS  = 20,
   parameter int         ROWS  = 8,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       vid_req_i,
   input  logic [7:0] vid_addr_i,
   input  logic       char_valid_i,
   input  logic [7:0] char_data_i,
   output logic       char_ready_o,
   output logic [7:0] mem_addr_o,
   output logic       mem_we_o,
   output logic [7:0] mem_wdata_o,
   output logic [7:0] cursor_pos_o,
   output logic       busy_o
);

   localparam logic [7:0] COLS8 = 8'(COLS);
   localparam logic [7:0] LAST  = 8'(COLS * ROWS - 1);
   localparam logic [8:0] NUM9  = 9'(COLS * ROWS);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

   state_t     state_q, state_d;
   logic [7:0] clr_addr_q, clr_addr_d;
   logic [7:0] cursor_q, cursor_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       wr_adv_q, wr_adv_d;
   logic [7:0] col;
   logic [8:0] lf_sum;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
         cursor_q   <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= BLANK;
         wr_adv_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         cursor_q   <= cursor_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_adv_q   <= wr_adv_d;
      end
   end

   assign col    = cursor_q % COLS8;
   assign lf_sum = {1'b0, cursor_q} + {1'b0, COLS8};

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      cursor_d   = cursor_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_adv_d   = wr_adv_q;
      case (state_q)
         S_IDLE: begin
            if (char_valid_i) begin
               if (char_data_i >= 8'h20 && char_data_i <= 8'h7E) begin
                  wr_addr_d = cursor_q;
                  wr_data_d = char_data_i;
                  wr_adv_d  = 1'b1;
                  state_d   = S_WRITE;
               end else begin
                  case (char_data_i)
                     8'h0D: cursor_d = cursor_q - col;
                     8'h0A: begin
                        if (lf_sum > {1'b0, LAST}) begin
`ifdef TEXT_WRAP_CLEAR_EN
                           state_d    = S_CLEAR;
                           clr_addr_d = '0;
`else
                           cursor_d = 8'(lf_sum - NUM9);
`endif
                        end else begin
                           cursor_d = lf_sum[7:0];
                        end
                     end
                     8'h08: begin
                        // Backspace blanks the previous cell and leaves the cursor on it
                        if (col != 8'd0) begin
                           cursor_d  = cursor_q - 8'd1;
                           wr_addr_d = cursor_q - 8'd1;
                           wr_data_d = BLANK;
                           wr_adv_d  = 1'b0;
                           state_d   = S_WRITE;
                        end
                     end
                     8'h0C: begin
                        state_d    = S_CLEAR;
                        clr_addr_d = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_WRITE: begin
            if (!vid_req_i) begin
               state_d = S_IDLE;
               if (wr_adv_q) begin
                  if (cursor_q == LAST) begin
`ifdef TEXT_WRAP_CLEAR_EN
                     state_d    = S_CLEAR;
                     clr_addr_d = '0;
`else
                     cursor_d = '0;
`endif
                  end else begin
                     cursor_d = cursor_q + 8'd1;
                  end
               end
            end
         end
         S_CLEAR: begin
            if (!vid_req_i) begin
               if (clr_addr_q == LAST) begin
                  state_d    = S_IDLE;
                  clr_addr_d = '0;
                  cursor_d   = '0;
               end else begin
                  clr_addr_d = clr_addr_q + 8'd1;
               end
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // Video reader always wins the shared address port
   always_comb begin
      char_ready_o = (state_q == S_IDLE) && !rst_i;
      busy_o       = (state_q != S_IDLE);
      mem_we_o     = (state_q != S_IDLE) && !vid_req_i && !rst_i;
      mem_wdata_o  = (state_q == S_WRITE && !rst_i) ? wr_data_q : BLANK;
      if (vid_req_i)                mem_addr_o = vid_addr_i;
      else if (state_q == S_CLEAR)  mem_addr_o = clr_addr_q;
      else                          mem_addr_o = wr_addr_q;
      cursor_pos_o = cursor_q;
   end

endmodule

// File: tb/tb_text_mem_ctrl.sv
// Directed bench for text_mem_ctrl: models the text RAM and checks hand-computed results.
// Wrap expectations follow TEXT_WRAP_CLEAR_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_text_mem_ctrl;

   logic       clk = 1'b0;
   logic       rst, vid_req, char_valid, char_ready, mem_we, busy;
   logic [7:0] vid_addr, char_data, mem_addr, mem_wdata, cursor;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram [256];
   bit         ram_init = 1'b0;
   int         wcount = 0;

   text_mem_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .vid_req_i    (vid_req),
      .vid_addr_i   (vid_addr),
      .char_valid_i (char_valid),
      .char_data_i  (char_data),
      .char_ready_o (char_ready),
      .mem_addr_o   (mem_addr),
      .mem_we_o     (mem_we),
      .mem_wdata_o  (mem_wdata),
      .cursor_pos_o (cursor),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'hFF;
         ram_init <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
         wcount <= wcount + 1;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      char_valid = 1'b1;
      char_data  = b;
      while (!char_ready && n < 500) begin
         step;
         n++;
      end
      checks++;
      if (n >= 500) begin
         errors++;
         $display("FAIL send_ready_timeout byte %h got no ready after %0d cycles", b, n);
      end
      step;
      char_valid = 1'b0;
   endtask

   task automatic print(input logic [7:0] b);
      send(b);
      step;
   endtask

   task automatic run_clear(input int stall_every, output int writes, output int cycles,
                            output int stalls);
      int w0;
      w0 = wcount;
      cycles = 0;
      stalls = 0;
      while (!char_ready && cycles < 1000) begin
         vid_req = (stall_every != 0) && (cycles % stall_every == 1);
         if (vid_req) stalls++;
         step;
         cycles++;
      end
      vid_req = 1'b0;
      writes = wcount - w0;
   endtask

   task automatic test_reset;
      int w, c, s;
      rst = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b0 || char_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_we_ready got we=%b ready=%b exp we=0 ready=0", mem_we, char_ready);
      end
      step;
      checks++;
      if (busy !== 1'b1 || cursor !== 8'd0 || char_ready !== 1'b0 || mem_wdata !== 8'h20) begin
         errors++;
         $display("FAIL reset_state got busy=%b cur=%0d ready=%b wdata=%h exp 1 0 0 20",
                  busy, cursor, char_ready, mem_wdata);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 8'd0) begin
         errors++;
         $display("FAIL reset_first_clear got we=%b addr=%0d exp we=1 addr=0", mem_we, mem_addr);
      end
      run_clear(0, w, c, s);
      checks++;
      if (w != 160 || c != 160) begin
         errors++;
         $display("FAIL reset_clear_len got writes=%0d cycles=%0d exp 160 160", w, c);
      end
      checks++;
      if (ram[0] !== 8'h20 || ram[159] !== 8'h20 || ram[160] !== 8'hFF || cursor !== 8'd0) begin
         errors++;
         $display("FAIL reset_clear_ram got r0=%h r159=%h r160=%h cur=%0d exp 20 20 ff 0",
                  ram[0], ram[159], ram[160], cursor);
      end
   endtask

   task automatic test_print;
      checks++;
      if (cursor !== 8'd0 || char_ready !== 1'b1) begin
         errors++;
         $display("FAIL print_pre got cur=%0d ready=%b exp 0 1", cursor, char_ready);
      end
      char_valid = 1'b1;
      char_data  = 8'h41;
      step;
      char_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 8'h41 || char_ready !== 1'b0
          || busy !== 1'b1) begin
         errors++;
         $display("FAIL print_write_cycle got we=%b addr=%0d wd=%h ready=%b busy=%b exp 1 0 41 0 1",
                  mem_we, mem_addr, mem_wdata, char_ready, busy);
      end
      step;
      checks++;
      if (ram[0] !== 8'h41 || cursor !== 8'd1 || char_ready !== 1'b1) begin
         errors++;
         $display("FAIL print_A got ram0=%h cur=%0d ready=%b exp 41 1 1", ram[0], cursor, char_ready);
      end
      print(8'h42);
      checks++;
      if (ram[1] !== 8'h42 || cursor !== 8'd2) begin
         errors++;
         $display("FAIL print_B got ram1=%h cur=%0d exp 42 2", ram[1], cursor);
      end
   endtask

   task automatic test_stall;
      int w0;
      w0 = wcount;
      send(8'h43);
      vid_req  = 1'b1;
      vid_addr = 8'hC8;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (mem_we !== 1'b0 || mem_addr !== 8'hC8 || cursor !== 8'd2) begin
            errors++;
            $display("FAIL stall_cycle%0d got we=%b addr=%h cur=%0d exp 0 c8 2",
                     i, mem_we, mem_addr, cursor);
         end
         step;
      end
      vid_req = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 8'd2 || mem_wdata !== 8'h43) begin
         errors++;
         $display("FAIL stall_release got we=%b addr=%0d wd=%h exp 1 2 43", mem_we, mem_addr, mem_wdata);
      end
      step;
      checks++;
      if (cursor !== 8'd3 || ram[2] !== 8'h43 || wcount - w0 != 1 || ram[8'hC8] !== 8'hFF) begin
         errors++;
         $display("FAIL stall_commit got cur=%0d ram2=%h writes=%0d ramc8=%h exp 3 43 1 ff",
                  cursor, ram[2], wcount - w0, ram[8'hC8]);
      end
   endtask

   task automatic test_ctrl;
      int w0;
      send(8'h0A);
      checks++;
      if (cursor !== 8'd23 || char_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ctrl_lf got cur=%0d ready=%b busy=%b exp 23 1 0", cursor, char_ready, busy);
      end
      print(8'h61);
      print(8'h62);
      checks++;
      if (cursor !== 8'd25) begin
         errors++;
         $display("FAIL ctrl_to25 got cur=%0d exp 25", cursor);
      end
      send(8'h0D);
      checks++;
      if (cursor !== 8'd20) begin
         errors++;
         $display("FAIL ctrl_cr got cur=%0d exp 20", cursor);
      end
      w0 = wcount;
      send(8'h08);
      checks++;
      if (cursor !== 8'd20 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ctrl_bs_col0 got cur=%0d busy=%b exp 20 0", cursor, busy);
      end
      send(8'h01);
      step;
      checks++;
      if (cursor !== 8'd20 || busy !== 1'b0 || wcount != w0) begin
         errors++;
         $display("FAIL ctrl_ignored got cur=%0d busy=%b writes=%0d exp 20 0 0",
                  cursor, busy, wcount - w0);
      end
      print(8'h41);
      checks++;
      if (ram[20] !== 8'h41 || cursor !== 8'd21) begin
         errors++;
         $display("FAIL ctrl_print20 got ram20=%h cur=%0d exp 41 21", ram[20], cursor);
      end
      send(8'h08);
      checks++;
      if (cursor !== 8'd20 || mem_we !== 1'b1 || mem_addr !== 8'd20 || mem_wdata !== 8'h20) begin
         errors++;
         $display("FAIL ctrl_bs_write got cur=%0d we=%b addr=%0d wd=%h exp 20 1 20 20",
                  cursor, mem_we, mem_addr, mem_wdata);
      end
      step;
      checks++;
      if (ram[20] !== 8'h20 || cursor !== 8'd20 || char_ready !== 1'b1) begin
         errors++;
         $display("FAIL ctrl_bs_done got ram20=%h cur=%0d ready=%b exp 20 20 1",
                  ram[20], cursor, char_ready);
      end
   endtask

   task automatic test_back_to_back;
      char_valid = 1'b1;
      char_data  = 8'h0A;
      step;
      checks++;
      if (cursor !== 8'd40 || char_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_lf1 got cur=%0d ready=%b exp 40 1", cursor, char_ready);
      end
      step;
      checks++;
      if (cursor !== 8'd60 || char_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_lf2 got cur=%0d ready=%b exp 60 1", cursor, char_ready);
      end
      char_valid = 1'b0;
   endtask

   task automatic test_wrap;
      int w, c, s;
      for (int i = 0; i < 4; i++) send(8'h0A);
      for (int i = 0; i < 19; i++) print(8'h30 + 8'(i));
      checks++;
      if (cursor !== 8'd159 || ram[140] !== 8'h30 || ram[158] !== 8'h42) begin
         errors++;
         $display("FAIL wrap_fill got cur=%0d r140=%h r158=%h exp 159 30 42", cursor, ram[140], ram[158]);
      end
      print(8'h5A);
      checks++;
      if (ram[159] !== 8'h5A) begin
         errors++;
         $display("FAIL wrap_last_write got r159=%h exp 5a", ram[159]);
      end
`ifdef TEXT_WRAP_CLEAR_EN
      run_clear(0, w, c, s);
      checks++;
      if (w != 160 || cursor !== 8'd0 || ram[140] !== 8'h20 || ram[159] !== 8'h20) begin
         errors++;
         $display("FAIL wrap_clear got writes=%0d cur=%0d r140=%h r159=%h exp 160 0 20 20",
                  w, cursor, ram[140], ram[159]);
      end
`else
      w = 0; c = 0; s = 0;
      checks++;
      if (cursor !== 8'd0 || busy !== 1'b0 || ram[140] !== 8'h30 || ram[0] !== 8'h41) begin
         errors++;
         $display("FAIL wrap_cursor got cur=%0d busy=%b r140=%h r0=%h exp 0 0 30 41 (w%0d c%0d s%0d)",
                  cursor, busy, ram[140], ram[0], w, c, s);
      end
`endif
      for (int i = 0; i < 7; i++) send(8'h0A);
      print(8'h51);
      checks++;
      if (cursor !== 8'd141 || ram[140] !== 8'h51) begin
         errors++;
         $display("FAIL wrap_row7 got cur=%0d r140=%h exp 141 51", cursor, ram[140]);
      end
      send(8'h0A);
`ifdef TEXT_WRAP_CLEAR_EN
      run_clear(0, w, c, s);
      checks++;
      if (w != 160 || cursor !== 8'd0 || ram[140] !== 8'h20) begin
         errors++;
         $display("FAIL wrap_lf_clear got writes=%0d cur=%0d r140=%h exp 160 0 20", w, cursor, ram[140]);
      end
`else
      checks++;
      if (cursor !== 8'd1 || busy !== 1'b0 || ram[140] !== 8'h51) begin
         errors++;
         $display("FAIL wrap_lf got cur=%0d busy=%b r140=%h exp 1 0 51", cursor, busy, ram[140]);
      end
`endif
   endtask

   task automatic test_clear_stall;
      int w, c, s;
      send(8'h0C);
      checks++;
      if (busy !== 1'b1 || char_ready !== 1'b0) begin
         errors++;
         $display("FAIL ff_enter got busy=%b ready=%b exp 1 0", busy, char_ready);
      end
      run_clear(3, w, c, s);
      checks++;
      if (w != 160 || c != 160 + s || s == 0) begin
         errors++;
         $display("FAIL ff_stall_len got writes=%0d cycles=%0d stalls=%0d exp 160 160+stalls",
                  w, c, s);
      end
      checks++;
      if (cursor !== 8'd0 || ram[140] !== 8'h20 || ram[159] !== 8'h20 || ram[160] !== 8'hFF
          || ram[255] !== 8'hFF) begin
         errors++;
         $display("FAIL ff_ram got cur=%0d r140=%h r159=%h r160=%h r255=%h exp 0 20 20 ff ff",
                  cursor, ram[140], ram[159], ram[160], ram[255]);
      end
   endtask

   task automatic test_reset_mid_clear;
      int w, c, s, n;
      print(8'h4B);
      send(8'h0C);
      n = 0;
      while (mem_addr !== 8'd80 && n < 500) begin
         step;
         n++;
      end
      checks++;
      if (n >= 500 || mem_we !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_reach80 got addr=%0d we=%b after %0d cycles exp 80 1", mem_addr, mem_we, n);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b0 || char_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_we_drop got we=%b ready=%b exp 0 0", mem_we, char_ready);
      end
      step;
      rst = 1'b0;
      #1;
      checks++;
      if (mem_addr !== 8'd0 || mem_we !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_restart got addr=%0d we=%b exp 0 1", mem_addr, mem_we);
      end
      run_clear(0, w, c, s);
      checks++;
      if (w != 160 || c != 160 || cursor !== 8'd0 || ram[0] !== 8'h20) begin
         errors++;
         $display("FAIL rstmid_clear got writes=%0d cycles=%0d cur=%0d r0=%h exp 160 160 0 20",
                  w, c, cursor, ram[0]);
      end
   endtask

   initial begin
      rst        = 1'b1;
      vid_req    = 1'b0;
      vid_addr   = 8'd0;
      char_valid = 1'b0;
      char_data  = 8'd0;
      test_reset;
      test_print;
      test_stall;
      test_ctrl;
      test_back_to_back;
      test_wrap;
      test_clear_stall;
      test_reset_mid_clear;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/text_mem_ctrl.md
# text_mem_ctrl

Write-side controller for the 256×8 character RAM that the VGA text pipeline reads symbol codes from. It accepts a stream of ASCII bytes, interprets a small set of terminal control codes, and keeps a cursor. It performs blank-fill clears and shares the RAM's single address port with the video reader, which always has priority. It sits between the character source (UART or keyboard decoder) and the text memory.

## Interface
- COLS, 20: symbols per text row
- ROWS, 8: text rows; COLS*ROWS must be ≤ 256 (default 160 visible symbols)
- BLANK, 8'h20: code written by clear and backspace
- clk  in  1  system/pixel clock
- rst  in  1  reset; synchronous, active-high (already decided)
- vidReq  in  1  video reader owns the RAM address this cycle
- vidAddr  in  8  symbol number requested by the video reader
- charValid  in  1  charData is valid
- charData  in  8  ASCII byte from the source
- charReady  out  1  block accepts a byte this cycle
- memAddr  out  8  RAM address
- memWe  out  1  RAM write enable
- memWdata  out  8  RAM write data
- cursorPos  out  8  current cursor symbol number, 0..COLS*ROWS-1
- busy  out  1  high in WRITE or CLEAR

## Operation
- Let NUM = COLS*ROWS. All state is updated on the rising edge of clk.
- There are three states: IDLE, WRITE and CLEAR. Reset enters CLEAR, so the screen is blanked after reset.
- A byte is accepted when charValid & charReady. charReady = (state == IDLE) & ~rst.
- On acceptance in IDLE:
  - 0x20..0x7E: latch the byte at the cursor and go to WRITE.
  - 0x0D (CR): cursor ← cursor − (cursor mod COLS). Stay in IDLE.
  - 0x0A (LF): cursor ← cursor + COLS, or cursor + COLS − NUM if that exceeds NUM−1. Stay in IDLE.
  - 0x08 (BS): if cursor mod COLS ≠ 0, cursor ← cursor−1 and go to WRITE with BLANK, without advancing. Otherwise the byte is ignored.
  - 0x0C (FF): go to CLEAR.
  - Any other byte is consumed and ignored.
- WRITE: memAddr = write address, memWdata = latched byte, memWe = ~vidReq. On the cycle the write commits (vidReq low):
  - If the write was printable, the cursor advances, wrapping NUM−1 → 0.
  - The state returns to IDLE.
- CLEAR: clrAddr counts 0..NUM−1 and writes BLANK, advancing only on cycles with vidReq low.
  - After the write to NUM−1 commits: cursor ← 0, state ← IDLE.
  - Addresses NUM..255 are never written.
- Arbitration uses a combinational mux:
  - memAddr = vidReq ? vidAddr : (CLEAR ? clrAddr : write address).
  - memWe is forced to 0 whenever vidReq or rst is high.
- busy = (state ≠ IDLE).

## Timing
- Reset values:
  - state CLEAR, clrAddr 0, cursorPos 0.
  - charReady 0, busy 1, memWe 0.
  - memWdata BLANK; memAddr follows the mux.
- Printable byte accepted in cycle N:
  - Write occurs in cycle N+1 if vidReq is low there, otherwise in the first later cycle with vidReq low.
  - cursorPos updates at the end of the write cycle.
  - charReady is high in the cycle after the write.
- CR and LF update cursorPos at the end of the accept cycle; charReady stays high, so back-to-back acceptance is allowed.
- A full clear takes NUM cycles plus one for every cycle with vidReq high.
- vidReq high in WRITE or CLEAR stalls the operation; no write is lost and no write is duplicated.
- rst asserted mid-WRITE or mid-CLEAR:
  - memWe drops in the same cycle.
  - The next cycle starts a fresh CLEAR from address 0; a pending byte is discarded.
- Video reads are never delayed; vidAddr reaches memAddr combinationally.

## Configuration
- TEXT_WRAP_CLEAR_EN is undefined:
  - A printable write at NUM−1 wraps the cursor to 0.
  - LF on the last row wraps to the same column of row 0.
  - Old text remains on screen.
- TEXT_WRAP_CLEAR_EN is defined:
  - A printable write at NUM−1 and an LF on the last row both enter CLEAR instead of wrapping.
  - The cursor ends at 0 after the clear.

## Test plan
- Reset held 1 cycle, vidReq=0 → memWe high for exactly 160 cycles writing 0x20 to addresses 0..159. charReady rises in the cycle after address 159. cursorPos=0.
- Send 'A','B' (0x41, 0x42) → RAM[0]=0x41, RAM[1]=0x42, cursorPos=2. Each write occurs 1 cycle after acceptance.
- vidReq held high for 5 cycles during a WRITE → memWe=0 and memAddr=vidAddr throughout. The write commits on the first cycle vidReq is low. cursorPos advances exactly once.
- Cursor at 25:
  - 0x0D → cursorPos=20.
  - 0x08 at cursor 20 → ignored.
  - 0x41 then 0x08 → RAM[20]=0x20, cursorPos=20.
- Cursor at 159, send 'Z' → RAM[159]=0x5A.
  - Without TEXT_WRAP_CLEAR_EN: cursorPos=0 and screen text unchanged.
  - With TEXT_WRAP_CLEAR_EN: 160 blank writes follow, then cursorPos=0.
- rst pulsed at clear address 80 → the next cycle shows memAddr=0 and memWe=1. The full 160-write clear completes.
